// File: rtl/cbg_bank_pkg.sv
// Shared widths, per-port slice offsets and the queued-request record
// used by the CBG bank, its request FIFOs and its bus interface.
package cbg_bank_pkg;

  localparam int SEL_W   = 3;
  localparam int DATA_W  = 32;
  localparam int MAX_A_W = 16;

  localparam int R_Q     = 4;
  localparam int W_Q     = 36;
  localparam int C_L_bus = 33;

  // Bit offsets inside one port's slice of each bus
  localparam int R_REN_OFS  = 0;
  localparam int R_SEL_OFS  = 1;
  localparam int W_DATA_OFS = 0;
  localparam int W_WEN_OFS  = 32;
  localparam int W_SEL_OFS  = 33;
  localparam int C_DIN_OFS  = 0;
  localparam int C_VLD_OFS  = 32;

  function automatic int a_bus(input int aw);
    return SEL_W + aw;
  endfunction

  typedef struct packed {
    logic               rd;
    logic               wr;
    logic [MAX_A_W-1:0] addr;
    logic [DATA_W-1:0]  wdata;
  } entry_t;

endpackage

// File: rtl/cbg_bank_if.sv
// LSU-facing buses of one CBG bank: requests in, read returns and status out.
interface cbg_bank_if #(
  parameter int NUM_PORTS = 4,
  parameter int A_W       = 10
);
  import cbg_bank_pkg::*;

  logic [NUM_PORTS*R_Q-1:0]        R_request_bus;
  logic [NUM_PORTS*W_Q-1:0]        W_request_bus;
  logic [NUM_PORTS*a_bus(A_W)-1:0] LSU_addr_bus;
  logic [NUM_PORTS*C_L_bus-1:0]    CBG_to_LSU_bus;
  logic [NUM_PORTS-1:0]            overflow;
  logic                            busy;

  modport master (
    output R_request_bus, W_request_bus, LSU_addr_bus,
    input  CBG_to_LSU_bus, overflow, busy
  );

  modport slave (
    input  R_request_bus, W_request_bus, LSU_addr_bus,
    output CBG_to_LSU_bus, overflow, busy
  );

endinterface

// File: rtl/cbg_bank_req_fifo.sv
// Per-port request queue; a push into a full queue is accepted only when
// the head is popped in the same cycle, otherwise it is reported as a drop.
module cbg_req_fifo
  import cbg_bank_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_push,
  input  logic   i_pop,
  input  entry_t i_data,
  output logic   o_full,
  output logic   o_empty,
  output logic   o_drop,
  output entry_t o_head
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t           r_mem [DEPTH];
  logic [PTR_W:0]   r_wptr;
  logic [PTR_W:0]   r_rptr;
  logic             w_pop;
  logic             w_push;

  // Pointers carry a wrap bit so full and empty are distinguishable
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = ((r_wptr ^ r_rptr) == {1'b1, {PTR_W{1'b0}}});
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_drop  = i_push & o_full & ~w_pop;
  assign o_head  = r_mem[r_rptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[PTR_W-1:0]] <= i_data;
  end

endmodule

// File: rtl/cbg_bank.sv
// One CBG memory bank: filters LSU requests by bank id, queues them per port,
// serves one per cycle round-robin into a read-first RAM, returns read data.
module cbg_bank
  import cbg_bank_pkg::*;
#(
  parameter int         NUM_PORTS  = 4,
  parameter logic [2:0] BANK_ID    = 3'd0,
  parameter int         A_W        = 10,
  parameter int         FIFO_DEPTH = 4
) (
  input logic       clk,
  input logic       rst,
  cbg_bank_if.slave io_cbg
);

  localparam int               A_BUS    = a_bus(A_W);
  localparam int               PTR_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int               RAM_D    = 1 << A_W;
  localparam logic [PTR_W-1:0] LAST_P   = PTR_W'(NUM_PORTS - 1);
  localparam logic [PTR_W:0]   NP_WIDE  = (PTR_W + 1)'(NUM_PORTS);

  logic [NUM_PORTS-1:0] w_push;
  logic [NUM_PORTS-1:0] w_pop;
  logic [NUM_PORTS-1:0] w_full;
  logic [NUM_PORTS-1:0] w_empty;
  logic [NUM_PORTS-1:0] w_drop;
  entry_t               w_head [NUM_PORTS];

  logic                 w_grant_vld;
  logic [PTR_W-1:0]     w_grant;
  logic [PTR_W:0]       w_cand;
  entry_t               w_gnt_entry;
  logic                 w_unused_addr;

  logic [PTR_W-1:0]     r_rr_ptr;
  logic [NUM_PORTS-1:0] r_overflow;
  logic [DATA_W-1:0]    r_ram [RAM_D];
  logic [DATA_W-1:0]    r_rdata;
  logic                 r_rvld;
  logic [PTR_W-1:0]     r_rport;
  logic [NUM_PORTS-1:0] r_read_valid;
  logic [DATA_W-1:0]    r_din [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [R_Q-1:0]   w_r;
    logic [W_Q-1:0]   w_w;
    logic [A_BUS-1:0] w_a;
    logic             w_addr_hit;
    logic             w_rd_hit;
    logic             w_wr_hit;
    entry_t           w_entry;

    assign w_r        = io_cbg.R_request_bus[p*R_Q +: R_Q];
    assign w_w        = io_cbg.W_request_bus[p*W_Q +: W_Q];
    assign w_a        = io_cbg.LSU_addr_bus[p*A_BUS +: A_BUS];
    assign w_addr_hit = (w_a[A_W +: SEL_W] == BANK_ID);
    assign w_rd_hit   = w_r[R_REN_OFS] & (w_r[R_SEL_OFS +: SEL_W] == BANK_ID) & w_addr_hit;
    assign w_wr_hit   = w_w[W_WEN_OFS] & (w_w[W_SEL_OFS +: SEL_W] == BANK_ID) & w_addr_hit;
    assign w_push[p]  = w_rd_hit | w_wr_hit;
    assign w_entry    = '{rd: w_rd_hit, wr: w_wr_hit,
                          addr: MAX_A_W'(w_a[A_W-1:0]),
                          wdata: w_w[W_DATA_OFS +: DATA_W]};

    cbg_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push[p]),
      .i_pop   (w_pop[p]),
      .i_data  (w_entry),
      .o_full  (w_full[p]),
      .o_empty (w_empty[p]),
      .o_drop  (w_drop[p]),
      .o_head  (w_head[p])
    );

    assign io_cbg.CBG_to_LSU_bus[p*C_L_bus + C_VLD_OFS]           = r_read_valid[p];
    assign io_cbg.CBG_to_LSU_bus[p*C_L_bus + C_DIN_OFS +: DATA_W] = r_din[p];
  end

  assign io_cbg.overflow = r_overflow;
  assign io_cbg.busy     = ~&w_empty;

  // Search starts at rr_ptr and wraps; the first non-empty queue wins
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = r_rr_ptr;
    w_cand      = '0;
    w_pop       = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_cand = {1'b0, r_rr_ptr} + (PTR_W + 1)'(i);
      if (w_cand >= NP_WIDE) w_cand = w_cand - NP_WIDE;
      if (!w_grant_vld && !w_empty[w_cand[PTR_W-1:0]]) begin
        w_grant_vld = 1'b1;
        w_grant     = w_cand[PTR_W-1:0];
      end
    end
    if (rst) w_grant_vld = 1'b0;
    if (w_grant_vld) w_pop[w_grant] = 1'b1;
  end

  assign w_gnt_entry   = w_head[w_grant];
  assign w_unused_addr = ^w_gnt_entry.addr[MAX_A_W-1:A_W];

  // Read-first single-port RAM: a rd&wr entry sees the pre-write word
  always_ff @(posedge clk) begin
    if (w_grant_vld) begin
      r_rdata <= r_ram[w_gnt_entry.addr[A_W-1:0]];
      if (w_gnt_entry.wr) r_ram[w_gnt_entry.addr[A_W-1:0]] <= w_gnt_entry.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr     <= '0;
      r_overflow   <= '0;
      r_rvld       <= 1'b0;
      r_rport      <= '0;
      r_read_valid <= '0;
      for (int p = 0; p < NUM_PORTS; p++) r_din[p] <= '0;
    end else begin
      r_overflow   <= r_overflow | w_drop;
      r_rvld       <= w_grant_vld & w_gnt_entry.rd;
      r_rport      <= w_grant;
      r_read_valid <= '0;
      if (w_grant_vld) r_rr_ptr <= (w_grant == LAST_P) ? '0 : w_grant + 1'b1;
      if (r_rvld) begin
        r_read_valid[r_rport] <= 1'b1;
        r_din[r_rport]        <= r_rdata;
      end
    end
  end

endmodule

// File: tb/tb_cbg_bank.sv
// Self-checking bench for cbg_bank: table vectors plus multi-cycle sequences,
// read data checked against per-port expected queues filled at drive time.
module tb_cbg_bank;

  localparam int         NP  = 4;
  localparam int         AW  = 10;
  localparam int         FD  = 4;
  localparam logic [2:0] BID = 3'd0;

  logic clk = 1'b0;
  logic rst;

  cbg_bank_if #(.NUM_PORTS(NP), .A_W(AW)) bus ();

  cbg_bank #(
    .NUM_PORTS  (NP),
    .BANK_ID    (BID),
    .A_W        (AW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_cbg (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    bit          ren;
    bit          wen;
    logic [2:0]  rsel;
    logic [2:0]  wsel;
    logic [2:0]  asel;
    logic [9:0]  addr;
    logic [31:0] wdata;
    bit          expEnq;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  int          cycle = 0;
  bit          monOn = 1'b0;
  logic [31:0] modelMem [1024];
  logic [31:0] expQ [NP][$];
  int          retPort[$];
  int          retCycle[$];
  vec_t        vecs[$];

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Every read_valid pulse must match the oldest outstanding read of its port
  always @(negedge clk) begin
    if (!rst && monOn) begin
      for (int p = 0; p < NP; p++) begin
        if (bus.CBG_to_LSU_bus[p*33+32]) begin
          retPort.push_back(p);
          retCycle.push_back(cycle);
          if (expQ[p].size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_read_valid: port %0d got din %0h expected no pulse", p,
                     bus.CBG_to_LSU_bus[p*33 +: 32]);
          end else begin
            checkOutput($sformatf("rdata_p%0d", p), 64'(bus.CBG_to_LSU_bus[p*33 +: 32]),
                        64'(expQ[p].pop_front()));
          end
        end
      end
    end
  end

  function automatic bit anyExp();
    for (int p = 0; p < NP; p++) if (expQ[p].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clearInputs();
    bus.R_request_bus = '0;
    bus.W_request_bus = '0;
    bus.LSU_addr_bus  = '0;
  endtask

  task automatic applyStimulus(input int p, input bit ren, input bit wen,
                               input logic [2:0] rsel, input logic [2:0] wsel,
                               input logic [2:0] asel, input logic [9:0] addr,
                               input logic [31:0] wdata, input bit accept);
    bus.R_request_bus[p*4 +: 4]   = {rsel, ren};
    bus.W_request_bus[p*36 +: 36] = {wsel, wen, wdata};
    bus.LSU_addr_bus[p*13 +: 13]  = {asel, addr};
    if (accept && ren) expQ[p].push_back(modelMem[addr]);
    if (accept && wen) modelMem[addr] = wdata;
  endtask

  task automatic waitDrain(input int maxCycles);
    int n = 0;
    bit pending = 1'b1;
    while (pending && n < maxCycles) begin
      @(negedge clk);
      n++;
      pending = bus.busy || anyExp();
    end
    checkOutput("drain", 64'(pending), 64'd0);
  endtask

  task automatic addVec(input int port, input bit ren, input bit wen, input logic [2:0] rsel,
                        input logic [2:0] wsel, input logic [2:0] asel, input logic [9:0] addr,
                        input logic [31:0] wdata, input bit expEnq);
    vec_t v;
    v.port = port; v.ren = ren; v.wen = wen; v.rsel = rsel; v.wsel = wsel;
    v.asel = asel; v.addr = addr; v.wdata = wdata; v.expEnq = expEnq;
    vecs.push_back(v);
  endtask

  // Which overflow-burst cycles each port gets accepted, starting from rr_ptr 0
  bit [7:0] accMask [NP];

  initial begin
    accMask[0] = 8'b0011_1111;
    accMask[1] = 8'b0101_1111;
    accMask[2] = 8'b1001_1111;
    accMask[3] = 8'b0001_1111;

    addVec(0, 1, 0, 3'd0, 3'd0, 3'd0, 10'd5, 32'h0,        0);
    vecs.delete();
    addVec(0, 0, 1, 3'd0, 3'd0, 3'd0, 10'd5, 32'hDEADBEEF, 1);
    addVec(0, 1, 0, 3'd0, 3'd0, 3'd0, 10'd5, 32'h0,        1);
    addVec(1, 1, 0, 3'd1, 3'd0, 3'd0, 10'd5, 32'h0,        0);
    addVec(1, 1, 0, 3'd0, 3'd0, 3'd2, 10'd5, 32'h0,        0);
    addVec(3, 0, 1, 3'd0, 3'd4, 3'd0, 10'd5, 32'h00000BAD, 0);
    addVec(3, 1, 0, 3'd0, 3'd0, 3'd0, 10'd5, 32'h0,        1);
    addVec(2, 0, 1, 3'd0, 3'd0, 3'd0, 10'd7, 32'h00000011, 1);
    addVec(2, 1, 1, 3'd0, 3'd0, 3'd0, 10'd7, 32'h00000022, 1);
    addVec(2, 1, 0, 3'd0, 3'd0, 3'd0, 10'd7, 32'h0,        1);
    addVec(1, 0, 1, 3'd0, 3'd0, 3'd0, 10'd9, 32'hCAFE0001, 1);
    addVec(1, 1, 0, 3'd0, 3'd0, 3'd0, 10'd9, 32'h0,        1);
    addVec(3, 1, 1, 3'd0, 3'd0, 3'd1, 10'd9, 32'h12345678, 0);
    addVec(1, 1, 0, 3'd0, 3'd0, 3'd0, 10'd9, 32'h0,        1);

    // Power-on reset
    rst = 1'b1;
    clearInputs();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_ret_bus", 64'(bus.CBG_to_LSU_bus), 64'd0);
    checkOutput("reset_overflow", 64'(bus.overflow), 64'd0);
    checkOutput("reset_busy", 64'(bus.busy), 64'd0);
    monOn = 1'b1;

    // Single-request vectors: enqueue decision seen on busy, data by the monitor
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].port, vecs[i].ren, vecs[i].wen, vecs[i].rsel, vecs[i].wsel,
                    vecs[i].asel, vecs[i].addr, vecs[i].wdata, vecs[i].expEnq);
      @(negedge clk);
      clearInputs();
      checkOutput($sformatf("vec%0d_busy", i), 64'(bus.busy), 64'(vecs[i].expEnq));
      repeat (3) @(negedge clk);
    end
    waitDrain(20);

    // Write then read back-to-back: pulse exactly three edges after the write
    @(negedge clk);
    applyStimulus(0, 0, 1, 3'd0, 3'd0, 3'd0, 10'd20, 32'h0BADF00D, 1);
    @(negedge clk);
    clearInputs();
    applyStimulus(0, 1, 0, 3'd0, 3'd0, 3'd0, 10'd20, 32'h0, 1);
    @(negedge clk);
    clearInputs();
    checkOutput("lat_e1", 64'(bus.CBG_to_LSU_bus[32]), 64'd0);
    @(negedge clk);
    checkOutput("lat_e2", 64'(bus.CBG_to_LSU_bus[32]), 64'd0);
    @(negedge clk);
    checkOutput("lat_e3", 64'(bus.CBG_to_LSU_bus[32]), 64'd1);
    @(negedge clk);
    checkOutput("lat_e4", 64'(bus.CBG_to_LSU_bus[32]), 64'd0);
    waitDrain(20);

    // Preload through port 0
    for (int a = 32; a < 64; a++) begin
      @(negedge clk);
      applyStimulus(0, 0, 1, 3'd0, 3'd0, 3'd0, 10'(a), 32'h5A000000 + 32'(a * 7), 1);
    end
    for (int a = 100; a < 104; a++) begin
      @(negedge clk);
      applyStimulus(0, 0, 1, 3'd0, 3'd0, 3'd0, 10'(a), 32'hC0DE0000 + 32'(a), 1);
    end
    @(negedge clk);
    clearInputs();
    waitDrain(20);

    // Plain reset so the burst below starts with rr_ptr at port 0
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Overflow burst: all ports read every cycle for 8 cycles
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (j == 5) checkOutput("ovf_before_full", 64'(bus.overflow), 64'h0);
      if (j == 6) checkOutput("ovf_first_drops", 64'(bus.overflow), 64'hE);
      for (int p = 0; p < NP; p++)
        applyStimulus(p, 1, 0, 3'd0, 3'd0, 3'd0, 10'(32 + p*8 + j), 32'h0, accMask[p][j]);
    end
    @(negedge clk);
    clearInputs();
    checkOutput("ovf_all", 64'(bus.overflow), 64'hF);
    waitDrain(60);
    checkOutput("ovf_sticky", 64'(bus.overflow), 64'hF);

    // Reset in the middle of traffic
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      for (int p = 0; p < NP; p++)
        applyStimulus(p, 1, 0, 3'd0, 3'd0, 3'd0, 10'(32 + p*8 + j), 32'h0, 1);
    end
    @(negedge clk);
    clearInputs();
    rst = 1'b1;
    for (int p = 0; p < NP; p++) expQ[p].delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("mid_reset_ret_bus", 64'(bus.CBG_to_LSU_bus), 64'd0);
    checkOutput("mid_reset_overflow", 64'(bus.overflow), 64'd0);
    checkOutput("mid_reset_busy", 64'(bus.busy), 64'd0);
    repeat (3) @(negedge clk);

    // Round-robin after reset: ports return 0,1,2,3 in consecutive cycles
    retPort.delete();
    retCycle.delete();
    @(negedge clk);
    for (int p = 0; p < NP; p++)
      applyStimulus(p, 1, 0, 3'd0, 3'd0, 3'd0, 10'(100 + p), 32'h0, 1);
    @(negedge clk);
    clearInputs();
    waitDrain(20);
    checkOutput("rr_count", 64'(retPort.size()), 64'(NP));
    for (int i = 0; i < retPort.size() && i < NP; i++) begin
      checkOutput($sformatf("rr_port%0d", i), 64'(retPort[i]), 64'(i));
      checkOutput($sformatf("rr_cycle%0d", i), 64'(retCycle[i] - retCycle[0]), 64'(i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop if the sequence itself never completes
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
